// File: rtl/data_mem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake with a fixed response latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        zext_q, zext_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             curWe;
  logic [31:0]      curAddr;
  logic [1:0]       curSize;
  logic             curZext;
  logic [31:0]      curWdata;
  logic [IDX_W-1:0] curIdx;
  logic             outOfRange;
  logic             misaligned;
  logic             fault;
  logic             enterResp;
  logic             memWe;
  logic [31:0]      memWord;
  logic [7:0]       loadByte;
  logic [15:0]      loadHalf;
  logic [31:0]      loadData;
  logic [3:0]       byteEn;
  logic [31:0]      laneData;

  // With LATENCY=1 the accept edge also enters RESP, so the live request fields must be used there.
  always_comb begin
    if (state_q == IDLE) begin
      curWe    = req_we;
      curAddr  = req_addr;
      curSize  = req_size;
      curZext  = req_unsigned;
      curWdata = req_wdata;
    end else begin
      curWe    = we_q;
      curAddr  = addr_q;
      curSize  = size_q;
      curZext  = zext_q;
      curWdata = wdata_q;
    end
  end

  assign curIdx     = curAddr[IDX_W+1:2];
  assign outOfRange = ({2'b00, curAddr[31:2]} >= DEPTH_WORDS);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = ((curSize == 2'b01) && curAddr[0]) ||
                      ((curSize == 2'b10) && (curAddr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign fault = outOfRange || (curSize == 2'b11) || misaligned;

  // Half lane is picked by addr[1] alone, so an odd half address is naturally aligned down.
  always_comb begin
    memWord  = mem[curIdx];
    loadByte = memWord[8*curAddr[1:0] +: 8];
    loadHalf = curAddr[1] ? memWord[31:16] : memWord[15:0];
    case (curSize)
      2'b00:   loadData = curZext ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
      2'b01:   loadData = curZext ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
      default: loadData = memWord;
    endcase
  end

  always_comb begin
    case (curSize)
      2'b00: begin
        byteEn   = 4'b0001 << curAddr[1:0];
        laneData = {4{curWdata[7:0]}};
      end
      2'b01: begin
        byteEn   = curAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{curWdata[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = curWdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    zext_d  = zext_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          zext_d  = req_unsigned;
          wdata_d = req_wdata;
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response data is frozen on the edge entering RESP so it stays stable while stalled.
    enterResp = (state_d == RESP) && (state_q != RESP);
    if (enterResp) begin
      err_d   = fault;
      rdata_d = (fault || curWe) ? 32'h0 : loadData;
    end
  end

  assign memWe = enterResp && curWe && !fault && !resetn;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      zext_q  <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem[curIdx][8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !resetn;
  assign rsp_valid = (state_q == RESP) && !resetn;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by random traffic
// compared against a byte-array memory model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] refMem [DEPTH*4];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: little-endian byte memory, natural alignment by masking, extension by arithmetic.
  function automatic void modelTxn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                   input logic uns, input logic [31:0] wdata,
                                   output logic [31:0] expRdata, output logic expErr);
    int unsigned ea;
    int unsigned nBytes;
    logic [31:0] v;
    expRdata = 32'h0;
    expErr   = (size == 2'b11) || ((addr >> 2) >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) expErr = 1'b1;
`endif
    if (expErr) return;
    nBytes = 1 << size;
    ea = addr & ~(nBytes - 1);
    if (we) begin
      for (int i = 0; i < int'(nBytes); i++) refMem[ea + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(nBytes); i++) v = v | (32'(refMem[ea + i]) << (8*i));
      if (!uns && nBytes < 4 && v[8*nBytes-1]) v = v | (32'hFFFF_FFFF << (8*nBytes));
      expRdata = v;
    end
  endfunction

  // One complete transaction: accept, latency, optional stall, handshake.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input int holdCycles,
                               output logic [31:0] rdata, output logic err);
    int cyc;
    logic [31:0] expRdata;
    logic expErr;
    rdata = 32'h0;
    err   = 1'b0;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("accept_ready", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    modelTxn(we, addr, size, uns, wdata, expRdata, expErr);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
    cyc = 1;
    while (!rsp_valid && cyc <= 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(LAT));
    checkOutput("rsp_rdata", rsp_rdata, expRdata);
    checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rdata", rsp_rdata, expRdata);
      checkOutput("hold_err", 32'(rsp_err), 32'(expErr));
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("post_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_rdata", rsp_rdata, 32'h0);
    checkOutput("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [31:0] a;
    logic [1:0]  sz;

    // Reset state
    #1;
    checkOutput("reset_req_ready_pre", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    resetn = 1'b0;
    #1;
    checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

    // Known contents for the low region used by all later traffic
    for (int w = 0; w < 128; w++) applyStimulus(1'b1, 32'(w*4), 2'b10, 1'b0, 32'h0, 0, rd, er);

    $display("[TB] word store/load");
    applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er);
    checkOutput("st_word_rdata", rd, 32'h0);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
    checkOutput("ld_word", rd, 32'hDEADBEEF);
    checkOutput("ld_word_err", 32'(er), 32'd0);

    $display("[TB] byte lanes and extension");
    applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
    applyStimulus(1'b1, 32'h13, 2'b00, 1'b0, 32'h80, 0, rd, er);
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, rd, er);
    checkOutput("ld_byte_signed", rd, 32'hFFFFFF80);
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, rd, er);
    checkOutput("ld_byte_unsigned", rd, 32'h00000080);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
    checkOutput("ld_word_after_byte", rd, 32'h80000000);

    $display("[TB] response stall");
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, rd, er);

    $display("[TB] out of range");
    applyStimulus(1'b1, 32'h0, 2'b10, 1'b0, 32'h01234567, 0, rd, er);
    applyStimulus(1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 0, rd, er);
    checkOutput("oor_ld_err", 32'(er), 32'd1);
    checkOutput("oor_ld_rdata", rd, 32'h0);
    applyStimulus(1'b1, 32'h1000, 2'b10, 1'b0, 32'hFFFFFFFF, 0, rd, er);
    checkOutput("oor_st_err", 32'(er), 32'd1);
    applyStimulus(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    checkOutput("oor_word0_kept", rd, 32'h01234567);

    $display("[TB] misaligned half store");
    applyStimulus(1'b1, 32'h21, 2'b01, 1'b0, 32'h0000ABCD, 0, rd, er);
    applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    checkOutput("misalign_word20", rd, 32'h00000000);
`else
    checkOutput("misalign_word20", rd, 32'h0000ABCD);
`endif

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFEF00D, 0, rd, er);
    req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'd0);
    resetn = 1'b1;
    #1;
    checkOutput("rst_wait_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_edge_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_edge_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_edge_rsp_err", 32'(rsp_err), 32'd0);
    resetn = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_after_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 0, rd, er);
    checkOutput("rst_store_dropped", rd, 32'hCAFEF00D);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 32'hFFFF);
      else a = 32'($urandom_range(0, 511));
      sz = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(1'($urandom), a, sz, 1'($urandom), $urandom, $urandom_range(0, 2), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
